dmem_resp_ctrl: RTL and testbench
=================================

Name: dmem_resp_ctrl

Overview:
- Parametrised data-memory responder: the RTL counterpart of the initiator/responder data-memory bus (complete_data, Data_dout, Data_din, Data_addr, Data_rd).
- Successor to the fixed 16-bit single-cycle data memory. Adds configurable data/address width, depth, and independent read/write wait states.
- Adds an explicit request strobe, a busy indication and an out-of-range error flag.
- Sits between the CPU core's memory stage and on-chip SRAM. Also serves as a reference responder in block-level benches.

Parameters:
- DATA_W, 16, data bus width in bits.
- ADDR_W, 16, address bus width in bits.
- DEPTH, 1024, number of DATA_W words implemented. Valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- RD_LAT, 2, read wait states (0..15).
- WR_LAT, 1, write wait states (0..15).

Ports:
- clock, input, 1, sole clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- Data_en, input, 1, request strobe; sampled only in IDLE.
- Data_rd, input, 1, 1 = read, 0 = write; sampled with Data_en.
- Data_addr, input, ADDR_W, word address; sampled with Data_en.
- Data_din, input, DATA_W, write data; sampled with Data_en.
- Data_dout, output, DATA_W, read data; valid while complete_data=1 on a read, then held.
- complete_data, output, 1, one-cycle completion pulse.
- Data_err, output, 1, out-of-range flag; asserted only together with complete_data.
- busy, output, 1, high while a request is in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; Data_dout=0; complete_data=0; Data_err=0; busy=0; wait counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If Data_en=1, latch Data_rd, Data_addr and Data_din.
  - Load the counter with RD_LAT (read) or WR_LAT (write).
  - Next state is WAIT if the loaded value > 0, else DONE.
  - Data_en=0: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter equals 1, next state is DONE.
  - Data_en is ignored in WAIT.
- DONE:
  - complete_data=1 for exactly this cycle; next state is IDLE.
  - Data_en is ignored in DONE, so the earliest next acceptance is the cycle after DONE.
- Latency: complete_data rises exactly LAT+1 clocks after the edge that accepted the request, where LAT is RD_LAT or WR_LAT.
- Read:
  - Data_dout is registered with mem[latched addr] on the edge entering DONE.
  - Data_dout holds that value until the next read completes.
  - Writes do not change Data_dout.
- Write:
  - mem[latched addr] is updated on the edge entering DONE.
  - This is the commit point.
- Read-after-write: a read accepted after a write's DONE returns the new data.
- Out of range (latched addr >= DEPTH):
  - The full latency is still honoured.
  - Data_err=1 with complete_data.
  - A write is discarded and memory is unchanged.
  - A read drives Data_dout=0.
- Input stability: inputs changing after acceptance have no effect, because only the latched copies are used.
- Reset mid-operation:
  - Returns to IDLE immediately; no completion pulse is produced.
  - A write whose DONE edge has not occurred is not committed.
- Width rules:
  - The address is compared at full ADDR_W width against DEPTH, with no truncation before the range check.
  - The internal index is the low clog2(DEPTH) bits.
- Protocol invariants:
  - complete_data is never high in two consecutive cycles.
  - busy=1 in WAIT and DONE.

Test Plan:
- Reset, then write 16'hBEEF to addr 16'h0010 with WR_LAT=1:
  - complete_data pulses at the 2nd edge after acceptance; Data_err=0.
  - Then read addr 16'h0010 with RD_LAT=2: complete_data pulses at the 3rd edge, Data_dout=16'hBEEF.
- Read with RD_LAT=0, WR_LAT=0:
  - complete_data pulses 1 edge after acceptance.
  - Back-to-back requests are accepted every 2 cycles; Data_en held high during DONE is ignored.
- Write to addr 16'h0400 with DEPTH=1024:
  - complete_data=1 and Data_err=1.
  - A subsequent read of addr 16'h0000 returns its prior value, unchanged.
  - A read of 16'h0400 returns Data_dout=0 with Data_err=1.
- Toggle Data_addr and Data_din every cycle during WAIT of a write of 16'h1234 to 16'h0005:
  - Memory at 16'h0005 = 16'h1234; no other location changes.
- Assert reset during WAIT of a write of 16'hAAAA to 16'h0020 (old value 16'h5555):
  - busy, complete_data and Data_dout drop to 0 asynchronously; no completion pulse.
  - A later read of 16'h0020 returns 16'h5555.
- Parameter sweep DATA_W=32, ADDR_W=12, DEPTH=4096, RD_LAT=15:
  - Write 32'hDEADBEEF to 12'hFFF, then read it back.
  - Data_dout=32'hDEADBEEF with the read's complete_data exactly 16 edges after acceptance; Data_err=0.

Source files
------------

// File: rtl/dmem_resp_ctrl_if.sv
// Initiator/responder data-memory bus: request strobe, direction, address, data and completion status.
// Responder returns complete_data and, on range violations, Data_err.
interface dmem_resp_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              Data_en;
  logic              Data_rd;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              complete_data;
  logic              Data_err;
  logic              busy;

  modport master (
    output Data_en, Data_rd, Data_addr, Data_din,
    input  Data_dout, complete_data, Data_err, busy
  );

  modport slave (
    input  Data_en, Data_rd, Data_addr, Data_din,
    output Data_dout, complete_data, Data_err, busy
  );
endinterface

// File: rtl/dmem_resp_ctrl.sv
// Data-memory responder with configurable read/write wait states; completion LAT+1 edges after accept.
// One request at a time: Data_en is only sampled in IDLE, so requests arriving while busy are ignored.
module dmem_resp_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  dmem_resp_ctrl_if.slave bus
);

  localparam int CNT_W = 4;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_rd;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  logic [DATA_W-1:0] dout_q;
  logic              cmp_q;
  logic              err_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_din;
  logic [CNT_W-1:0]  req_lat;
  logic              req_ok;
  logic [IDX_W-1:0]  req_idx;
  logic              enter_done;

  // In IDLE the request is still on the bus; afterwards only the latched copy counts.
  always_comb begin
    req_rd   = lat_rd;
    req_addr = lat_addr;
    req_din  = lat_din;
    if (state == IDLE) begin
      req_rd   = bus.Data_rd;
      req_addr = bus.Data_addr;
      req_din  = bus.Data_din;
    end
    req_lat    = req_rd ? CNT_W'(RD_LAT) : CNT_W'(WR_LAT);
    req_ok     = ({1'b0, req_addr} < DEPTH_EXT);
    req_idx    = req_addr[IDX_W-1:0];
    enter_done = 1'b0;
    if (state == IDLE) begin
      enter_done = bus.Data_en && (req_lat == '0);
    end else if (state == WAIT) begin
      enter_done = (cnt == CNT_W'(1));
    end
  end

  // Memory shares the async-reset process so a reset can never let a write slip through.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_rd   <= 1'b0;
      lat_addr <= '0;
      lat_din  <= '0;
      dout_q   <= '0;
      cmp_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cmp_q <= 1'b0;
      err_q <= 1'b0;
      if (enter_done && req_rd) begin
        dout_q <= req_ok ? mem[req_idx] : '0;
      end
      if (enter_done && !req_rd && req_ok) begin
        mem[req_idx] <= req_din;
      end
      case (state)
        IDLE: begin
          if (bus.Data_en) begin
            lat_rd   <= req_rd;
            lat_addr <= req_addr;
            lat_din  <= req_din;
            cnt      <= req_lat;
            busy_q   <= 1'b1;
            state    <= (req_lat != '0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          cmp_q  <= 1'b1;
          err_q  <= !req_ok;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Data_dout     = dout_q;
  assign bus.complete_data = cmp_q;
  assign bus.Data_err      = err_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Bench for dmem_resp_ctrl: three configurations checked every cycle against a cycle-arithmetic model,
// plus directed literal checks of latency, data, range errors and mid-operation reset.
module tb_dmem_resp_ctrl;

  logic clock;
  logic reset;

  int vectors = 0;
  int miscompares = 0;

  bit          drv_en   [3];
  bit          drv_rd   [3];
  logic [15:0] drv_addr [3];
  logic [31:0] drv_din  [3];

  wire [31:0] out_dout [3];
  wire        out_cmp  [3];
  wire        out_err  [3];
  wire        out_busy [3];

  int          rdl  [3] = '{2, 0, 15};
  int          wrl  [3] = '{1, 0, 3};
  int          dep  [3] = '{1024, 1024, 4096};
  logic [15:0] amsk [3] = '{16'hFFFF, 16'hFFFF, 16'h0FFF};
  logic [31:0] dmsk [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};
  logic [15:0] pool [3][10];

  dmem_resp_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
  dmem_resp_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  dmem_resp_ctrl_if #(.DATA_W(32), .ADDR_W(12)) bus2 ();

  assign bus0.Data_en   = drv_en[0];
  assign bus0.Data_rd   = drv_rd[0];
  assign bus0.Data_addr = drv_addr[0];
  assign bus0.Data_din  = drv_din[0][15:0];
  assign bus1.Data_en   = drv_en[1];
  assign bus1.Data_rd   = drv_rd[1];
  assign bus1.Data_addr = drv_addr[1];
  assign bus1.Data_din  = drv_din[1][15:0];
  assign bus2.Data_en   = drv_en[2];
  assign bus2.Data_rd   = drv_rd[2];
  assign bus2.Data_addr = drv_addr[2][11:0];
  assign bus2.Data_din  = drv_din[2];

  assign out_dout[0] = {16'h0000, bus0.Data_dout};
  assign out_dout[1] = {16'h0000, bus1.Data_dout};
  assign out_dout[2] = bus2.Data_dout;
  assign out_cmp[0]  = bus0.complete_data;
  assign out_cmp[1]  = bus1.complete_data;
  assign out_cmp[2]  = bus2.complete_data;
  assign out_err[0]  = bus0.Data_err;
  assign out_err[1]  = bus1.Data_err;
  assign out_err[2]  = bus2.Data_err;
  assign out_busy[0] = bus0.busy;
  assign out_busy[1] = bus1.busy;
  assign out_busy[2] = bus2.busy;

  dmem_resp_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(2), .WR_LAT(1)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  dmem_resp_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(0), .WR_LAT(0)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1));
  dmem_resp_ctrl #(.DATA_W(32), .ADDR_W(12), .DEPTH(4096), .RD_LAT(15), .WR_LAT(3)) u_dut2 (
    .clock(clock), .reset(reset), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pre_val(input int d, input logic [15:0] a);
    return (32'h5A5A0000 + 32'(a) * 32'h101 + 32'h0A0A + 32'(d)) & dmsk[d];
  endfunction

  // Model: a request accepted at edge n commits at n+LAT and completes at n+LAT+1.
  logic [31:0] mmem [int];
  int          cyc = 0;
  bit          was;
  bit          m_act [3];
  int          m_acc [3];
  int          m_lat [3];
  bit          m_rd  [3];
  bit          m_oob [3];
  logic [15:0] m_addr [3];
  logic [31:0] m_din  [3];
  logic [31:0] e_dout [3] = '{32'h0, 32'h0, 32'h0};
  bit          e_cmp  [3];
  bit          e_err  [3];
  bit          e_busy [3];

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int d = 0; d < 3; d++) begin
          m_act[d]  = 1'b0;
          e_cmp[d]  = 1'b0;
          e_err[d]  = 1'b0;
          e_busy[d] = 1'b0;
          e_dout[d] = 32'h0;
        end
      end else begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
          was = m_act[d];
          e_cmp[d] = 1'b0;
          e_err[d] = 1'b0;
          if (was && cyc == m_acc[d] + m_lat[d] + 1) begin
            e_cmp[d] = 1'b1;
            e_err[d] = m_oob[d];
            m_act[d] = 1'b0;
          end else if (!was && drv_en[d]) begin
            m_act[d]  = 1'b1;
            m_acc[d]  = cyc;
            m_rd[d]   = drv_rd[d];
            m_addr[d] = drv_addr[d] & amsk[d];
            m_din[d]  = drv_din[d] & dmsk[d];
            m_lat[d]  = drv_rd[d] ? rdl[d] : wrl[d];
            m_oob[d]  = (int'(m_addr[d]) >= dep[d]);
          end
          if (m_act[d] && cyc == m_acc[d] + m_lat[d]) begin
            if (m_rd[d]) begin
              e_dout[d] = m_oob[d] ? 32'h0 : mmem[d * 65536 + int'(m_addr[d])];
            end else if (!m_oob[d]) begin
              mmem[d * 65536 + int'(m_addr[d])] = m_din[d];
            end
          end
          e_busy[d] = m_act[d];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        chk("m_cmp", d, 32'(out_cmp[d]), 32'(e_cmp[d]));
        chk("m_err", d, 32'(out_err[d]), 32'(e_err[d]));
        chk("m_busy", d, 32'(out_busy[d]), 32'(e_busy[d]));
        chk("m_dout", d, out_dout[d], e_dout[d]);
      end
    end
  end

  // Issues one request from an idle DUT and scrambles the bus while it is in flight.
  task automatic do_req(input int d, input bit rd, input logic [15:0] addr, input logic [31:0] din,
                        output int edges, output logic [31:0] dout, output logic err);
    edges = -1;
    dout  = 32'h0;
    err   = 1'b0;
    @(negedge clock);
    drv_en[d]   = 1'b1;
    drv_rd[d]   = rd;
    drv_addr[d] = addr;
    drv_din[d]  = din;
    @(negedge clock);
    drv_en[d]   = 1'b0;
    drv_addr[d] = 16'($urandom) & amsk[d];
    drv_din[d]  = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (out_cmp[d]) begin
        edges = k;
        dout  = out_dout[d];
        err   = out_err[d];
        break;
      end
      drv_addr[d] = 16'($urandom) & amsk[d];
      drv_din[d]  = $urandom;
    end
    if (edges < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout dut%0d: no complete_data within 40 edges, expected one", d);
    end
  endtask

  initial begin
    int          e;
    int          cnt;
    logic [31:0] dv;
    logic        er;

    pool[0] = '{16'h0000, 16'h0004, 16'h0005, 16'h0006, 16'h0010, 16'h0020, 16'h03FF, 16'h0400, 16'h07FF, 16'hFFFF};
    pool[1] = pool[0];
    pool[2] = '{16'h0000, 16'h0004, 16'h0005, 16'h0006, 16'h0010, 16'h0020, 16'h0800, 16'h0FFE, 16'h0FFF, 16'h03FF};
    for (int d = 0; d < 3; d++) begin
      drv_en[d]   = 1'b0;
      drv_rd[d]   = 1'b0;
      drv_addr[d] = 16'h0;
      drv_din[d]  = 32'h0;
    end

    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", d, 32'(out_busy[d]), 32'h0);
      chk("rst_cmp", d, 32'(out_cmp[d]), 32'h0);
      chk("rst_err", d, 32'(out_err[d]), 32'h0);
      chk("rst_dout", d, out_dout[d], 32'h0);
    end
    reset = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 10; i++) begin
        if (int'(pool[d][i]) < dep[d]) begin
          do_req(d, 1'b0, pool[d][i], pre_val(d, pool[d][i]), e, dv, er);
        end
      end
    end

    do_req(0, 1'b0, 16'h0010, 32'h0000BEEF, e, dv, er);
    chk("wr_lat1", 0, 32'(e), 32'd2);
    chk("wr_err", 0, 32'(er), 32'h0);
    do_req(0, 1'b1, 16'h0010, 32'h0, e, dv, er);
    chk("rd_lat2", 0, 32'(e), 32'd3);
    chk("rd_beef", 0, dv, 32'h0000BEEF);

    do_req(1, 1'b1, 16'h0010, 32'h0, e, dv, er);
    chk("rd_lat0", 1, 32'(e), 32'd1);
    chk("rd_lat0_dout", 1, dv, 32'h00001A1B);
    @(negedge clock);
    drv_en[1]   = 1'b1;
    drv_rd[1]   = 1'b1;
    drv_addr[1] = 16'h0010;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (out_cmp[1]) cnt++;
      drv_addr[1] = pool[1][$urandom_range(0, 6)];
    end
    drv_en[1] = 1'b0;
    chk("b2b_count", 1, 32'(cnt), 32'd5);

    do_req(0, 1'b0, 16'h0400, 32'h00001111, e, dv, er);
    chk("oob_wr_lat", 0, 32'(e), 32'd2);
    chk("oob_wr_err", 0, 32'(er), 32'h1);
    do_req(0, 1'b1, 16'h0000, 32'h0, e, dv, er);
    chk("addr0_kept", 0, dv, 32'h00000A0A);
    chk("addr0_err", 0, 32'(er), 32'h0);
    do_req(0, 1'b1, 16'h0400, 32'h0, e, dv, er);
    chk("oob_rd_dout", 0, dv, 32'h0);
    chk("oob_rd_err", 0, 32'(er), 32'h1);

    do_req(0, 1'b0, 16'h0005, 32'h00001234, e, dv, er);
    do_req(0, 1'b1, 16'h0005, 32'h0, e, dv, er);
    chk("stable_5", 0, dv, 32'h00001234);
    do_req(0, 1'b1, 16'h0004, 32'h0, e, dv, er);
    chk("stable_4", 0, dv, 32'h00000E0E);
    do_req(0, 1'b1, 16'h0006, 32'h0, e, dv, er);
    chk("stable_6", 0, dv, 32'h00001010);

    do_req(0, 1'b0, 16'h0020, 32'h00005555, e, dv, er);
    do_req(0, 1'b1, 16'h0020, 32'h0, e, dv, er);
    chk("pre_rst_rd", 0, dv, 32'h00005555);
    @(negedge clock);
    drv_en[0]   = 1'b1;
    drv_rd[0]   = 1'b0;
    drv_addr[0] = 16'h0020;
    drv_din[0]  = 32'h0000AAAA;
    @(negedge clock);
    drv_en[0] = 1'b0;
    chk("wait_busy", 0, 32'(out_busy[0]), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(out_busy[0]), 32'h0);
    chk("arst_cmp", 0, 32'(out_cmp[0]), 32'h0);
    chk("arst_dout", 0, out_dout[0], 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    do_req(0, 1'b1, 16'h0020, 32'h0, e, dv, er);
    chk("rst_no_commit", 0, dv, 32'h00005555);

    do_req(2, 1'b0, 16'h0FFF, 32'hDEADBEEF, e, dv, er);
    chk("w32_lat", 2, 32'(e), 32'd4);
    do_req(2, 1'b1, 16'h0FFF, 32'h0, e, dv, er);
    chk("r32_lat", 2, 32'(e), 32'd16);
    chk("r32_dout", 2, dv, 32'hDEADBEEF);
    chk("r32_err", 2, 32'(er), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        drv_en[d]   = ($urandom_range(0, 2) == 0);
        drv_rd[d]   = $urandom_range(0, 1) == 1;
        drv_addr[d] = pool[d][$urandom_range(0, 9)];
        drv_din[d]  = $urandom;
      end
    end
    @(negedge clock);
    for (int d = 0; d < 3; d++) drv_en[d] = 1'b0;
    repeat (20) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
